norm_lut_stage: RTL and testbench

Streaming normalization stage that consumes samples from the preceding layer, drives the address/enable side of the normalization LUT ROM, and multiplies each sample's magnitude by the returned fixed-point scale factor. It sits directly in front of and around the LUT ROM instance and feeds the scaled result to the next pipeline stage. Valid/ready handshakes on both sides support full-rate operation and lossless backpressure.

---
 rtl/norm_lut_stage.sv | 94 +++++++++
 tb/tb_norm_lut_stage.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/norm_lut_stage.sv
// norm_lut_stage: streaming magnitude * LUT-scale normalizer.
// It drives the LUT ROM address and enable from the incoming sample. It
// holds the operand in S1 while the registered ROM read completes, then
// registers the signed, saturated, scaled result in OUT.
module norm_lut_stage #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 6,
    parameter int LUT_WIDTH  = 16,
    parameter int FRAC_BITS  = 14
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] lut_addr,
    output logic                  lut_enable,
    input  logic [LUT_WIDTH-1:0]  lut_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy
);

    localparam int PW = DATA_WIDTH + LUT_WIDTH;
    localparam logic [DATA_WIDTH-1:0] SMAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] SMIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic                  s1_valid;
    logic                  s1_sign;
    logic [DATA_WIDTH-1:0] s1_abs;
    logic [DATA_WIDTH-1:0] in_abs;
    logic                  accept;
    logic                  s1_advance;
    logic [PW-1:0]         prod;
    logic [PW-1:0]         mag;
    logic [DATA_WIDTH-1:0] mag_sat;
    logic [DATA_WIDTH-1:0] res;

    // Input magnitude; the most negative input has no positive twin, so clamp it.
    always_comb begin
        in_abs = in_data;
        if (in_data[DATA_WIDTH-1]) begin
            if (in_data == SMIN) in_abs = SMAX;
            else                 in_abs = -in_data;
        end
    end

    // Handshake: S1 frees up either when empty or when it moves into OUT this cycle.
    // in_ready is held low during reset so nothing is read from the ROM then.
    assign s1_advance = s1_valid && (!out_valid || out_ready);
    assign in_ready   = !reset && (!s1_valid || s1_advance);
    assign accept     = in_valid && in_ready;
    assign lut_enable = accept;
    assign lut_addr   = in_abs[DATA_WIDTH-2 -: ADDR_WIDTH];
    assign busy       = s1_valid | out_valid;

    // Scale: unsigned product, drop fraction bits, clamp to the positive max, reapply sign.
    always_comb begin
        prod    = PW'(s1_abs) * PW'(lut_data);
        mag     = prod >> FRAC_BITS;
        mag_sat = (mag > PW'(SMAX)) ? SMAX : mag[DATA_WIDTH-1:0];
        res     = (s1_sign && (mag_sat != '0)) ? -mag_sat : mag_sat;
    end

    // S1: operand held while the ROM read is in flight; reloads on accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_abs   <= '0;
            s1_sign  <= 1'b0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_abs   <= in_abs;
            s1_sign  <= in_data[DATA_WIDTH-1];
        end else if (s1_advance) begin
            s1_valid <= 1'b0;
        end
    end

    // OUT: result register; held while the consumer stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (s1_advance) begin
            out_valid <= 1'b1;
            out_data  <= res;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_norm_lut_stage.sv
// tb_norm_lut_stage: scoreboard bench for norm_lut_stage with a registered LUT ROM model.
module tb_norm_lut_stage;

    localparam int DW = 16;
    localparam int AW = 6;
    localparam int LW = 16;
    localparam int FB = 14;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [AW-1:0] lut_addr;
    logic          lut_enable;
    logic [LW-1:0] lut_data;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          busy;

    logic [LW-1:0] lut [64];
    logic [DW-1:0] exp_q [$];
    int            total = 0;
    int            bad = 0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;

    always #5 clk = ~clk;

    norm_lut_stage #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LUT_WIDTH(LW), .FRAC_BITS(FB)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .lut_addr(lut_addr), .lut_enable(lut_enable), .lut_data(lut_data),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );

    // ROM model: synchronous reset, one-cycle registered read gated by enable.
    always_ff @(posedge clk) begin
        if (reset)           lut_data <= '0;
        else if (lut_enable) lut_data <= lut[lut_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] model(input logic [DW-1:0] x);
        logic [DW-1:0] a;
        logic [31:0]   p;
        logic [DW-1:0] s;
        a = x;
        if (x[DW-1]) a = (x == 16'h8000) ? 16'h7FFF : -x;
        p = (32'(a) * 32'(lut[a[14:9]])) >> FB;
        s = (p > 32'h7FFF) ? 16'h7FFF : p[15:0];
        return x[DW-1] ? -s : s;
    endfunction

    // Monitor: pop and compare on every output transfer; check hold under stall.
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_data", 32'(out_data), 32'(prev_data));
            end
            if (out_valid && out_ready) begin
                chk("out_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) chk("out_data", 32'(out_data), 32'(exp_q.pop_front()));
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    // Offer one sample until accepted; expectation pushed at the handshake.
    task automatic send(input logic [DW-1:0] d, input logic [DW-1:0] e, output int waits);
        bit done = 0;
        waits = 0;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = d;
        while (!done && waits < 200) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(e);
                done = 1;
            end else begin
                waits++;
                @(posedge clk); #1;
            end
        end
        if (!done) chk("send_timeout", 32'd1, 32'd0);
    endtask

    task automatic idle();
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Single sample into an empty pipe: address, enable and two-cycle latency.
    task automatic lat_test(input logic [DW-1:0] d, input logic [AW-1:0] a, input logic [DW-1:0] e);
        int w;
        out_ready = 1'b1;
        send(d, e, w);
        chk("lat_no_wait", 32'(w), 32'd0);
        chk("lut_addr", 32'(lut_addr), 32'(a));
        chk("lut_enable", 32'(lut_enable), 32'd1);
        idle();
        @(negedge clk);
        chk("lat_c1_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("lat_c2_valid", 32'(out_valid), 32'd1);
        chk("lat_c2_data", 32'(out_data), 32'(e));
        @(negedge clk);
        chk("lat_c3_valid", 32'(out_valid), 32'd0);
    endtask

    task automatic drain(input int bound);
        int c = 0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || busy) && c < bound) begin
            @(negedge clk);
            c++;
        end
        chk("drain_timeout", 32'(c < bound), 32'd1);
    endtask

    initial begin
        int w;
        int stalls;
        int acc;
        int sent;
        int cyc;
        logic [DW-1:0] bp [4];
        logic [DW-1:0] d;

        for (int i = 0; i < 64; i++) lut[i] = 16'h4000;
        lut[8]  = 16'h4000;
        lut[63] = 16'hFFFF;

        // Reset state, with in_valid asserted to check gating.
        in_valid = 1'b1;
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_lut_enable", 32'(lut_enable), 32'd0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk("post_rst_lut_en_idle", 32'(lut_enable), 32'd0);

        // Basic, sign and saturation.
        lat_test(16'h1000, 6'd8, 16'h1000);
        lat_test(16'hF000, 6'd8, 16'hF000);
        lat_test(16'h7FFF, 6'd63, 16'h7FFF);
        lat_test(16'h8000, 6'd63, 16'h8001);
        lat_test(16'h0000, 6'd0, 16'h0000);

        // Full rate: eight back-to-back samples, never stalled.
        out_ready = 1'b1;
        stalls = 0;
        for (int i = 1; i <= 8; i++) begin
            send(16'(i * 16'h0200), 16'(i * 16'h0200), w);
            stalls += w;
        end
        idle();
        chk("fullrate_stalls", 32'(stalls), 32'd0);
        drain(50);

        // Backpressure: two held, third refused, output frozen.
        bp[0] = 16'h0100; bp[1] = 16'hFF00; bp[2] = 16'h0300; bp[3] = 16'h2000;
        @(posedge clk); #1;
        out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_data  = bp[acc];
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(bp[acc]);
                acc++;
            end
        end
        chk("bp_accepted", 32'(acc), 32'd2);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        chk("bp_out_data", 32'(out_data), 32'(bp[0]));
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        send(bp[2], bp[2], w);
        send(bp[3], bp[3], w);
        idle();
        drain(50);

        // Random stress against the reference model.
        sent = 0;
        cyc  = 0;
        while (sent < 2000 && cyc < 40000) begin
            @(posedge clk); #1;
            cyc++;
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 9))
                0:       d = 16'h8000;
                1:       d = 16'h7FFF;
                2:       d = 16'h0000;
                default: d = 16'($urandom);
            endcase
            in_data = d;
            @(negedge clk);
            if (in_valid && in_ready) begin
                exp_q.push_back(model(d));
                sent++;
            end
        end
        chk("rand_sent", 32'(sent), 32'd2000);
        idle();
        drain(200);

        // Reset with S1 and OUT both full.
        out_ready = 1'b0;
        send(16'h0400, 16'h0400, w);
        send(16'h0500, 16'h0500, w);
        @(posedge clk); #1;
        in_data = 16'h0600;
        #1;
        chk("pre_rst_busy", 32'(busy), 32'd1);
        chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        chk("mid_rst_lut_enable", 32'(lut_enable), 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        reset     = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("post_rst_quiet", 32'(out_valid), 32'd0);
        end
        lat_test(16'hF000, 6'd8, 16'hF000);
        drain(20);

        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("final_busy", 32'(busy), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
